// File: rtl/keystream_gen.sv
// Keystream generator: 16-bit Fibonacci LFSR, 16-shift warm-up, then one
// 8-bit keystream byte per 8 shifts, held under a valid/ready handshake.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for the first seed_load after reset, no shifting
// WARM  | discarding 16 LFSR bits after a (re)load
// GEN   | shifting 8 bits into the byte being built
// HOLD  | ks_byte valid, waiting for ks_ready
module keystream_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        seed_load,
  input  logic [15:0] seed,
  input  logic        ks_ready,
  output logic        ks_valid,
  output logic [7:0]  ks_byte,
  output logic        busy,
  output logic [7:0]  byte_cnt
);

  typedef enum logic [1:0] {IDLE, WARM, GEN, HOLD} state_t;

  localparam logic [15:0] SEED_DEFAULT = 16'hACE1;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  ks_byte_q, ks_byte_d;
  logic        ks_valid_q, ks_valid_d;
  logic [7:0]  byte_cnt_q, byte_cnt_d;

  logic        fb;
  logic [15:0] lfsr_step;

  assign fb        = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign lfsr_step = {lfsr_q[14:0], fb};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lfsr_q     <= 16'h0000;
      cnt_q      <= 4'd0;
      shift_q    <= 8'h00;
      ks_byte_q  <= 8'h00;
      ks_valid_q <= 1'b0;
      byte_cnt_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ks_byte_q  <= ks_byte_d;
      ks_valid_q <= ks_valid_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  // cnt_q is a down-counter of remaining shifts in the current phase.
  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    ks_byte_d  = ks_byte_q;
    ks_valid_d = ks_valid_q;
    byte_cnt_d = byte_cnt_q;
    if (ena) begin
      if (seed_load) begin
        lfsr_d     = (seed == 16'h0000) ? SEED_DEFAULT : seed;
        cnt_d      = 4'd15;
        shift_d    = 8'h00;
        byte_cnt_d = 8'h00;
        ks_valid_d = 1'b0;
        state_d    = WARM;
      end else begin
        unique case (state_q)
          IDLE: begin
          end
          WARM: begin
            lfsr_d = lfsr_step;
            if (cnt_q == 4'd0) begin
              cnt_d   = 4'd7;
              state_d = GEN;
            end else begin
              cnt_d = cnt_q - 4'd1;
            end
          end
          GEN: begin
            lfsr_d  = lfsr_step;
            shift_d = {shift_q[6:0], fb};
            if (cnt_q == 4'd0) begin
              ks_byte_d  = {shift_q[6:0], fb};
              ks_valid_d = 1'b1;
              state_d    = HOLD;
            end else begin
              cnt_d = cnt_q - 4'd1;
            end
          end
          HOLD: begin
            if (ks_ready) begin
              ks_valid_d = 1'b0;
              byte_cnt_d = byte_cnt_q + 8'd1;
              cnt_d      = 4'd7;
              state_d    = GEN;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  assign ks_valid = ks_valid_q;
  assign ks_byte  = ks_byte_q;
  assign byte_cnt = byte_cnt_q;
  assign busy     = (state_q == WARM) || (state_q == GEN);

endmodule

// File: tb/tb_keystream_gen.sv
// Self-checking bench for keystream_gen: directed scenarios plus randomized
// enable/ready/reload traffic against a byte-level behavioural model.
module tb_keystream_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        seed_load;
  logic [15:0] seed;
  logic        ks_ready;
  logic        ks_valid;
  logic [7:0]  ks_byte;
  logic        busy;
  logic [7:0]  byte_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] ref_q[$];

  keystream_gen dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .seed_load(seed_load), .seed(seed),
    .ks_ready(ks_ready), .ks_valid(ks_valid), .ks_byte(ks_byte), .busy(busy),
    .byte_cnt(byte_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Byte k of a keystream is the low byte of the LFSR after 24 + 8k shifts.
  task automatic gen_bytes(input logic [15:0] sd, input int n);
    logic [15:0] s;
    s = (sd == 16'h0000) ? 16'hACE1 : sd;
    ref_q.delete();
    for (int i = 0; i < 24; i++) s = lfsr_next(s);
    ref_q.push_back(s[7:0]);
    for (int k = 1; k < n; k++) begin
      for (int i = 0; i < 8; i++) s = lfsr_next(s);
      ref_q.push_back(s[7:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] sd);
    seed = sd; seed_load = 1'b1; ena = 1'b1;
    tick();
    seed_load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b0; seed_load = 1'b0; seed = 16'h0; ks_ready = 1'b0;
    #3;
    n_tests++;
    if ({ks_valid, busy, ks_byte, byte_cnt} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_vals: got v=%b b=%b byte=%h cnt=%h expected all zero", ks_valid, busy, ks_byte, byte_cnt);
    end
    tick(); tick();
    rst_n = 1'b1; ena = 1'b1; ks_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      n_tests++;
      if ({ks_valid, busy, ks_byte, byte_cnt} !== 18'h0) begin
        n_fail++;
        $display("FAIL idle_%0d: got v=%b b=%b byte=%h cnt=%h expected all zero", i, ks_valid, busy, ks_byte, byte_cnt);
      end
    end
    ks_ready = 1'b0;
  endtask

  task automatic test_first_byte(input logic [15:0] sd);
    logic [7:0] held;
    gen_bytes(sd, 1);
    ks_ready = 1'b0;
    do_load(sd);
    for (int e = 1; e <= 24; e++) begin
      n_tests++;
      if (ks_valid !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL warm_busy seed=%h edge=%0d: got v=%b b=%b expected v=0 b=1", sd, e - 1, ks_valid, busy);
      end
      tick();
    end
    n_tests++;
    if (ks_valid !== 1'b1 || busy !== 1'b0 || ks_byte !== ref_q[0] || ks_byte !== 8'hDD && (sd == 16'hACE1 || sd == 16'h0)) begin
      n_fail++;
      $display("FAIL first_byte seed=%h: got v=%b b=%b byte=%h expected v=1 b=0 byte=%h", sd, ks_valid, busy, ks_byte, ref_q[0]);
    end
    held = ref_q[0];
    for (int i = 0; i < 20; i++) begin
      tick();
      n_tests++;
      if (ks_valid !== 1'b1 || ks_byte !== held || byte_cnt !== 8'h00 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_stable seed=%h cyc=%0d: got v=%b byte=%h cnt=%h expected v=1 byte=%h cnt=00", sd, i, ks_valid, ks_byte, byte_cnt, held);
      end
    end
  endtask

  // Steady-state stream: valid every 9 enabled edges, byte_cnt counts handshakes.
  task automatic check_stream_edge(input int en, input string tag);
    logic       ev;
    logic [7:0] ecnt;
    ev   = (en >= 24) && ((en - 24) % 9 == 0);
    ecnt = (en < 25) ? 8'h00 : 8'(((en - 25) / 9) + 1);
    n_tests++;
    if (ks_valid !== ev || byte_cnt !== ecnt || (ev && ks_byte !== ref_q[(en - 24) / 9])) begin
      n_fail++;
      $display("FAIL %s edge=%0d: got v=%b byte=%h cnt=%h expected v=%b byte=%h cnt=%h", tag, en, ks_valid, ks_byte, byte_cnt,
               ev, ev ? ref_q[(en - 24) / 9] : ks_byte, ecnt);
    end
  endtask

  task automatic test_stream();
    logic saw_wrap;
    logic [7:0] prev_cnt;
    saw_wrap = 1'b0;
    gen_bytes(16'hACE1, 300);
    ks_ready = 1'b1;
    do_load(16'hACE1);
    prev_cnt = byte_cnt;
    for (int e = 1; e <= 24 + 9 * 299 + 1; e++) begin
      tick();
      check_stream_edge(e, "stream");
      if (prev_cnt == 8'hFF && byte_cnt == 8'h00) saw_wrap = 1'b1;
      prev_cnt = byte_cnt;
    end
    n_tests++;
    if (saw_wrap !== 1'b1) begin
      n_fail++;
      $display("FAIL cnt_wrap: got wrap=%b expected 1", saw_wrap);
    end
    ks_ready = 1'b0;
  endtask

  task automatic test_ena_toggle();
    int en;
    logic [17:0] snap;
    en = 0;
    gen_bytes(16'hACE1, 6);
    ks_ready = 1'b1;
    do_load(16'hACE1);
    for (int c = 0; c < 2 * (24 + 9 * 5); c++) begin
      ena = c[0];
      snap = {ks_valid, busy, ks_byte, byte_cnt};
      tick();
      if (ena) begin
        en++;
        check_stream_edge(en, "ena_toggle");
      end else begin
        n_tests++;
        if ({ks_valid, busy, ks_byte, byte_cnt} !== snap) begin
          n_fail++;
          $display("FAIL ena_frozen cyc=%0d: got %h expected %h", c, {ks_valid, busy, ks_byte, byte_cnt}, snap);
        end
      end
    end
    ena = 1'b1; ks_ready = 1'b0;
  endtask

  task automatic test_priority();
    ks_ready = 1'b0;
    do_load(16'h5A5A);
    repeat (24) tick();
    ks_ready = 1'b1; tick(); ks_ready = 1'b0;
    repeat (8) tick();
    n_tests++;
    if (ks_valid !== 1'b1 || byte_cnt !== 8'h01) begin
      n_fail++;
      $display("FAIL prio_setup: got v=%b cnt=%h expected v=1 cnt=01", ks_valid, byte_cnt);
    end
    gen_bytes(16'h1234, 1);
    ks_ready = 1'b1; seed = 16'h1234; seed_load = 1'b1;
    tick();
    seed_load = 1'b0; ks_ready = 1'b0;
    n_tests++;
    if (ks_valid !== 1'b0 || byte_cnt !== 8'h00 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL prio_load: got v=%b cnt=%h b=%b expected v=0 cnt=00 b=1", ks_valid, byte_cnt, busy);
    end
    repeat (24) tick();
    n_tests++;
    if (ks_valid !== 1'b1 || ks_byte !== ref_q[0] || byte_cnt !== 8'h00) begin
      n_fail++;
      $display("FAIL prio_newseed: got v=%b byte=%h cnt=%h expected v=1 byte=%h cnt=00", ks_valid, ks_byte, byte_cnt, ref_q[0]);
    end
  endtask

  task automatic test_reset_mid();
    ks_ready = 1'b0;
    do_load(16'hBEEF);
    repeat (20) tick();
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({ks_valid, busy, ks_byte, byte_cnt} !== 18'h0) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b b=%b byte=%h cnt=%h expected all zero", ks_valid, busy, ks_byte, byte_cnt);
    end
    tick();
    rst_n = 1'b1; ena = 1'b1; ks_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      n_tests++;
      if ({ks_valid, busy, ks_byte, byte_cnt} !== 18'h0) begin
        n_fail++;
        $display("FAIL post_reset_idle cyc=%0d: got v=%b b=%b byte=%h cnt=%h expected all zero", i, ks_valid, busy, ks_byte, byte_cnt);
      end
    end
    ks_ready = 1'b0;
    gen_bytes(16'h0F0F, 1);
    do_load(16'h0F0F);
    repeat (24) tick();
    n_tests++;
    if (ks_valid !== 1'b1 || ks_byte !== ref_q[0]) begin
      n_fail++;
      $display("FAIL reset_restart: got v=%b byte=%h expected v=1 byte=%h", ks_valid, ks_byte, ref_q[0]);
    end
  endtask

  // Random ena/ready/reload traffic against a byte-level model.
  task automatic test_random();
    logic [15:0] m_s;
    logic [7:0]  m_byte, m_cnt;
    logic        m_valid;
    int          m_wait;
    logic [15:0] sd;
    sd = 16'(($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 65535));
    do_load(sd);
    m_s = (sd == 16'h0) ? 16'hACE1 : sd;
    m_wait = 24; m_valid = 1'b0; m_cnt = 8'h00; m_byte = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      ena       = ($urandom_range(0, 3) != 0);
      ks_ready  = $urandom_range(0, 1);
      seed_load = ($urandom_range(0, 199) == 0);
      seed      = 16'(($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 65535));
      if (ena) begin
        if (seed_load) begin
          m_s = (seed == 16'h0) ? 16'hACE1 : seed;
          m_wait = 24; m_valid = 1'b0; m_cnt = 8'h00;
        end else if (m_valid) begin
          if (ks_ready) begin
            m_valid = 1'b0; m_cnt = m_cnt + 8'd1; m_wait = 8;
          end
        end else if (m_wait > 0) begin
          m_s = lfsr_next(m_s);
          m_wait--;
          if (m_wait == 0) begin
            m_valid = 1'b1; m_byte = m_s[7:0];
          end
        end
      end
      tick();
      n_tests++;
      if (ks_valid !== m_valid || byte_cnt !== m_cnt || busy !== (m_wait > 0 && !m_valid) || (m_valid && ks_byte !== m_byte)) begin
        n_fail++;
        $display("FAIL random cyc=%0d: got v=%b b=%b byte=%h cnt=%h expected v=%b b=%b byte=%h cnt=%h", c, ks_valid, busy, ks_byte,
                 byte_cnt, m_valid, (m_wait > 0 && !m_valid), m_byte, m_cnt);
      end
    end
    seed_load = 1'b0; ena = 1'b1; ks_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_byte(16'hACE1);
    test_first_byte(16'h0000);
    test_stream();
    test_ena_toggle();
    test_priority();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
